snake_body_engine: RTL and testbench
====================================

# snake_body_engine

Parametrised snake motion and body engine for the VGA snake game. It keeps the head and up to MAX_LEN−1 body segments as packed X/Y coordinate buses and advances them one cell per `step` tick. Each step applies the latched direction and any pending growth, then checks the move for wall and self-collision. It sits between the button debouncer/tick generator and the renderer/food logic, and replaces the fixed-size per-clock position controller.

## Interface
- GRID_W, 640: playfield width in cells; legal X range 0..GRID_W−1
- GRID_H, 480: playfield height in cells; legal Y range 0..GRID_H−1
- COORD_W, 10: bits per coordinate; must satisfy 2^COORD_W ≥ max(GRID_W, GRID_H)
- MAX_LEN, 100: maximum segment count, head included
- LEN_W, 7: width of `length`; must satisfy 2^LEN_W > MAX_LEN
- START_X, 320 / START_Y, 120: head position after reset
- WRAP, 1: 1 = wrap at edges; 0 = leaving the grid kills the snake
- clock  in  1  system clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- step  in  1  one-cycle movement tick
- buttons  in  4  level inputs: [0] left, [1] down, [2] right, [3] up
- grow  in  1  one-cycle pulse: lengthen by one segment on the next step
- pos_x, pos_y  out  MAX_LEN*COORD_W  packed coordinates; segment k at [k*COORD_W +: COORD_W], k=0 is the head
- length  out  LEN_W  number of live segments, 1..MAX_LEN
- dir  out  2  current heading: 0 left, 1 down, 2 right, 3 up
- alive  out  1  high in IDLE and RUN, low in DEAD
- hit  out  1  one-cycle pulse on the step that causes death
- moved  out  1  one-cycle pulse on every step that advanced the snake

## Operation
- FSM states:
  - IDLE: reset state; `step` has no effect.
  - RUN: the snake moves.
  - DEAD: everything frozen; only reset_n leaves DEAD.
- Transitions:
  - IDLE→RUN on the first cycle any button is high. `dir` is loaded from the button and the snake does not move that cycle.
  - RUN→DEAD on a collision step.
- Direction request: priority left > down > right > up. It is latched every cycle into `dir`.
- Reversal rule: a request opposite to `dir` is ignored while length > 1. It is accepted when length = 1.
- Grow: a `grow` pulse sets `grow_pend`. Pulses while it is already set are merged into one. `grow_pend` is consumed on the next RUN step.
- Next head: head ± 1 on one axis, per `dir`.
  - WRAP=1: −1 becomes the max coordinate (GRID_W−1 or GRID_H−1); max+1 becomes 0.
  - WRAP=0: an out-of-range next head is a collision.
- Arithmetic is signed with COORD_W+1 bits, so −1 is detectable.
- Effective length after the step: L' = min(length + grow_pend, MAX_LEN).
- Self-collision: the next head equals any current segment k with 1 ≤ k ≤ L'−2.
  - The current tail (k = length−1) is excluded when not growing, because it vacates on this step.
  - The current head (k = 0) is never compared.
- Non-collision step:
  - Every segment shifts: seg[k] ← seg[k−1] for k ≥ 1, then the new head is written to seg[0].
  - `length` ← L'; `grow_pend` is cleared; `moved` pulses.
- Collision step:
  - Positions and `length` do not change.
  - State goes to DEAD; `hit` pulses; `moved` stays low; `grow_pend` is cleared.
- Dead segments: every segment with k ≥ length reads as 0 on both X and Y after every update.
- Saturation: `grow` at length = MAX_LEN is consumed with no effect.

## Timing
- Reset (asynchronous):
  - seg[0] = (START_X, START_Y); all other segments 0.
  - length = 1, dir = 0, state IDLE, alive = 1, hit = 0, moved = 0, grow_pend = 0.
- All outputs are registered. A step sampled at edge n is visible after edge n; `moved`/`hit` are high for exactly that cycle.
- `step` and a button change in the same cycle: the step uses `dir` from before the change, and the new `dir` applies from the next step.
- `step` and `grow` in the same cycle: the step uses the prior `grow_pend`; the new pulse is held for the following step.
- Back-to-back `step` on consecutive cycles is legal; each one advances one cell.
- reset_n asserted mid-step: reset wins immediately, with no partial shift visible.

## Test plan
- Reset, press right (buttons=4'b0100), then 3 steps → head (323,120), length 1, 3 `moved` pulses. No motion before the press.
- Head at (0,120) heading left, WRAP=1, step → head (639,120). With WRAP=0 instead → `hit` pulse, alive=0, head stays (0,120).
- 4 grow+step pairs while moving right from (320,120) → length 5, segments (324..320,120) in order, seg[5..] = 0.
- length 3 heading right, press left → dir stays 2; length 1, press left → dir becomes 0.
- length 5, step through down, left, up so the head re-enters body cell seg[3] → `hit` on that step, positions frozen. Length 4 on the same square path with the tail vacating → no hit.
- grow pulses at length = MAX_LEN, then step → length stays MAX_LEN. reset_n low in the middle of this → all reset values on the next observation.

Source files
------------

// File: rtl/snake_body_engine.sv
// Snake motion and body engine: holds head plus up to MAX_LEN-1 body segments
// as packed X/Y buses and advances them one cell per step tick, applying the
// latched direction, pending growth, and wall/self-collision detection.
// Ports:
//   clock, reset_n       system clock, async active-low reset
//   step                 one-cycle movement tick
//   buttons[3:0]         level direction requests: [0] left [1] down [2] right [3] up
//   grow                 one-cycle pulse, lengthen by one on the next step
//   pos_x, pos_y         packed segment coordinates, segment k at [k*COORD_W +: COORD_W]
//   length               live segment count
//   dir                  heading: 0 left, 1 down, 2 right, 3 up
//   alive, hit, moved    status: not dead / death pulse / advance pulse
module snake_body_engine #(
  parameter int unsigned GRID_W  = 640,
  parameter int unsigned GRID_H  = 480,
  parameter int unsigned COORD_W = 10,
  parameter int unsigned MAX_LEN = 100,
  parameter int unsigned LEN_W   = 7,
  parameter int unsigned START_X = 320,
  parameter int unsigned START_Y = 120,
  parameter int unsigned WRAP    = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       step,
  input  logic [3:0]                 buttons,
  input  logic                       grow,
  output logic [MAX_LEN*COORD_W-1:0] pos_x,
  output logic [MAX_LEN*COORD_W-1:0] pos_y,
  output logic [LEN_W-1:0]           length,
  output logic [1:0]                 dir,
  output logic                       alive,
  output logic                       hit,
  output logic                       moved
);

  localparam int unsigned PW = MAX_LEN * COORD_W;
  localparam int unsigned SW = COORD_W + 1;
  localparam int unsigned EW = LEN_W + 1;
  localparam logic signed [SW-1:0] MAX_X = SW'(GRID_W - 1);
  localparam logic signed [SW-1:0] MAX_Y = SW'(GRID_H - 1);
  localparam logic [EW-1:0] MAX_L = EW'(MAX_LEN);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} state_t;

  state_t            state, state_next;
  logic              grow_pend, grow_pend_next;
  logic [PW-1:0]     pos_x_next, pos_y_next;
  logic [LEN_W-1:0]  length_next;
  logic [1:0]        dir_next, req_dir;
  logic              alive_next, hit_next, moved_next;

  logic signed [SW-1:0] hx, hy, nx, ny;
  logic [COORD_W-1:0]   new_x, new_y;
  logic                 out_x, out_y, wall, self_hit;
  logic [EW-1:0]        len_sum, new_len;

  // Button priority: left > down > right > up
  always_comb begin : req_decode
    if (buttons[0])      req_dir = 2'd0;
    else if (buttons[1]) req_dir = 2'd1;
    else if (buttons[2]) req_dir = 2'd2;
    else                 req_dir = 2'd3;
  end

  // Candidate head one signed bit wider so that -1 is visible before wrapping
  always_comb begin : head_calc
    hx = signed'({1'b0, pos_x[COORD_W-1:0]});
    hy = signed'({1'b0, pos_y[COORD_W-1:0]});
    nx = hx;
    ny = hy;
    case (dir)
      2'd0:    nx = hx - SW'(1);
      2'd1:    ny = hy + SW'(1);
      2'd2:    nx = hx + SW'(1);
      default: ny = hy - SW'(1);
    endcase
    out_x = 1'b0;
    out_y = 1'b0;
    new_x = nx[COORD_W-1:0];
    new_y = ny[COORD_W-1:0];
    if (nx[SW-1]) begin
      out_x = 1'b1;
      new_x = COORD_W'(GRID_W - 1);
    end else if (nx > MAX_X) begin
      out_x = 1'b1;
      new_x = '0;
    end
    if (ny[SW-1]) begin
      out_y = 1'b1;
      new_y = COORD_W'(GRID_H - 1);
    end else if (ny > MAX_Y) begin
      out_y = 1'b1;
      new_y = '0;
    end
    wall = (WRAP == 0) && (out_x || out_y);
  end

  // Post-step length and self-collision against segments 1..L'-2
  always_comb begin : body_check
    len_sum  = EW'(length) + EW'(grow_pend);
    new_len  = (len_sum > MAX_L) ? MAX_L : len_sum;
    self_hit = 1'b0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if ((EW'(k) + EW'(2) <= new_len) &&
          (pos_x[k*COORD_W +: COORD_W] == new_x) &&
          (pos_y[k*COORD_W +: COORD_W] == new_y))
        self_hit = 1'b1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin : fsm_next
    state_next     = state;
    dir_next       = dir;
    grow_pend_next = grow_pend;
    pos_x_next     = pos_x;
    pos_y_next     = pos_y;
    length_next    = length;
    alive_next     = alive;
    hit_next       = 1'b0;
    moved_next     = 1'b0;
    case (state)
      IDLE: begin
        if (grow) grow_pend_next = 1'b1;
        if (|buttons) begin
          state_next = RUN;
          dir_next   = req_dir;
        end
      end
      RUN: begin
        if (grow) grow_pend_next = 1'b1;
        // Reversal into own neck is only refused once a neck exists
        if ((|buttons) && ((req_dir != (dir ^ 2'd2)) || (length == LEN_W'(1))))
          dir_next = req_dir;
        if (step) begin
          if (wall || self_hit) begin
            state_next     = DEAD;
            alive_next     = 1'b0;
            hit_next       = 1'b1;
            grow_pend_next = 1'b0;
          end else begin
            grow_pend_next = grow;
            length_next    = new_len[LEN_W-1:0];
            moved_next     = 1'b1;
            pos_x_next[COORD_W-1:0] = new_x;
            pos_y_next[COORD_W-1:0] = new_y;
            for (int k = 1; k < MAX_LEN; k++) begin
              if (EW'(k) < new_len) begin
                pos_x_next[k*COORD_W +: COORD_W] = pos_x[(k-1)*COORD_W +: COORD_W];
                pos_y_next[k*COORD_W +: COORD_W] = pos_y[(k-1)*COORD_W +: COORD_W];
              end else begin
                pos_x_next[k*COORD_W +: COORD_W] = '0;
                pos_y_next[k*COORD_W +: COORD_W] = '0;
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin : regs
    if (!reset_n) begin
      state     <= IDLE;
      pos_x     <= PW'(START_X);
      pos_y     <= PW'(START_Y);
      length    <= LEN_W'(1);
      dir       <= 2'd0;
      grow_pend <= 1'b0;
      alive     <= 1'b1;
      hit       <= 1'b0;
      moved     <= 1'b0;
    end else begin
      state     <= state_next;
      pos_x     <= pos_x_next;
      pos_y     <= pos_y_next;
      length    <= length_next;
      dir       <= dir_next;
      grow_pend <= grow_pend_next;
      alive     <= alive_next;
      hit       <= hit_next;
      moved     <= moved_next;
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: a wrapping instance and a non-wrapping
// instance share all stimulus; expected values are hand-computed constants.
module tb_snake_body_engine;
  localparam int CW = 10;
  localparam int ML = 100;
  localparam int LW = 7;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic step = 1'b0;
  logic grow = 1'b0;
  logic [3:0] buttons = 4'b0000;
  logic [ML*CW-1:0] px, py, px_w, py_w;
  logic [LW-1:0] len, len_w;
  logic [1:0] dir, dir_w;
  logic alive, hit, moved, alive_w, hit_w, moved_w;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  snake_body_engine dut (
    .clock(clock), .reset_n(reset_n), .step(step), .buttons(buttons), .grow(grow),
    .pos_x(px), .pos_y(py), .length(len), .dir(dir),
    .alive(alive), .hit(hit), .moved(moved)
  );

  snake_body_engine #(.WRAP(0)) dut_nowrap (
    .clock(clock), .reset_n(reset_n), .step(step), .buttons(buttons), .grow(grow),
    .pos_x(px_w), .pos_y(py_w), .length(len_w), .dir(dir_w),
    .alive(alive_w), .hit(hit_w), .moved(moved_w)
  );

  function automatic int sx(input int k); return int'(px[k*CW +: CW]); endfunction
  function automatic int sy(input int k); return int'(py[k*CW +: CW]); endfunction
  function automatic int wx(input int k); return int'(px_w[k*CW +: CW]); endfunction

  task automatic cyc(); @(posedge clock); #1; endtask
  task automatic apply_reset();
    reset_n = 1'b0; step = 1'b0; grow = 1'b0; buttons = 4'b0000;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask
  task automatic press(input logic [3:0] b); buttons = b; cyc(); buttons = 4'b0000; endtask
  task automatic step1(); step = 1'b1; cyc(); step = 1'b0; endtask
  task automatic grow_step();
    grow = 1'b1; cyc(); grow = 1'b0;
    step = 1'b1; cyc(); step = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (sx(0) !== 320) begin failures++; $display("FAIL reset_head_x got=%0d exp=320", sx(0)); end
    checks++; if (sy(0) !== 120) begin failures++; $display("FAIL reset_head_y got=%0d exp=120", sy(0)); end
    checks++; if (len !== 7'd1) begin failures++; $display("FAIL reset_length got=%0d exp=1", len); end
    checks++; if (dir !== 2'd0) begin failures++; $display("FAIL reset_dir got=%0d exp=0", dir); end
    checks++; if (alive !== 1'b1 || hit !== 1'b0 || moved !== 1'b0) begin failures++; $display("FAIL reset_flags got alive=%b hit=%b moved=%b exp 1 0 0", alive, hit, moved); end
    checks++; if (sx(1) !== 0 || sy(1) !== 0) begin failures++; $display("FAIL reset_seg1 got=(%0d,%0d) exp=(0,0)", sx(1), sy(1)); end
    step1();
    checks++; if (sx(0) !== 320 || moved !== 1'b0) begin failures++; $display("FAIL idle_step got x=%0d moved=%b exp x=320 moved=0", sx(0), moved); end
  endtask

  task automatic test_start_move();
    int n;
    apply_reset();
    buttons = 4'b0100; step = 1'b1; cyc(); buttons = 4'b0000; step = 1'b0;
    checks++; if (dir !== 2'd2) begin failures++; $display("FAIL start_dir got=%0d exp=2", dir); end
    checks++; if (sx(0) !== 320 || moved !== 1'b0) begin failures++; $display("FAIL start_no_move got x=%0d moved=%b exp x=320 moved=0", sx(0), moved); end
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step1();
      if (moved === 1'b1) n++;
    end
    checks++; if (n !== 3) begin failures++; $display("FAIL start_moved_count got=%0d exp=3", n); end
    checks++; if (sx(0) !== 323 || sy(0) !== 120) begin failures++; $display("FAIL start_head got=(%0d,%0d) exp=(323,120)", sx(0), sy(0)); end
    checks++; if (len !== 7'd1) begin failures++; $display("FAIL start_length got=%0d exp=1", len); end
    cyc();
    checks++; if (moved !== 1'b0) begin failures++; $display("FAIL moved_pulse_width got=%b exp=0", moved); end
  endtask

  task automatic test_grow();
    apply_reset();
    press(4'b0100);
    for (int i = 0; i < 4; i++) grow_step();
    checks++; if (len !== 7'd5) begin failures++; $display("FAIL grow_length got=%0d exp=5", len); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (sx(k) !== 324 - k || sy(k) !== 120) begin failures++; $display("FAIL grow_seg%0d got=(%0d,%0d) exp=(%0d,120)", k, sx(k), sy(k), 324 - k); end
    end
    checks++; if (sx(5) !== 0 || sy(5) !== 0 || sx(99) !== 0) begin failures++; $display("FAIL grow_dead_segs got seg5=(%0d,%0d) seg99x=%0d exp zeros", sx(5), sy(5), sx(99)); end
  endtask

  // Continues from test_grow: length 5, head (324,120) heading right
  task automatic test_self_hit();
    press(4'b0010); step1();
    checks++; if (sx(0) !== 324 || sy(0) !== 121) begin failures++; $display("FAIL square_down got=(%0d,%0d) exp=(324,121)", sx(0), sy(0)); end
    press(4'b0001); step1();
    checks++; if (sx(0) !== 323 || sy(0) !== 121) begin failures++; $display("FAIL square_left got=(%0d,%0d) exp=(323,121)", sx(0), sy(0)); end
    press(4'b1000); step1();
    checks++; if (hit !== 1'b1 || alive !== 1'b0 || moved !== 1'b0) begin failures++; $display("FAIL self_hit_flags got hit=%b alive=%b moved=%b exp 1 0 0", hit, alive, moved); end
    checks++; if (sx(0) !== 323 || sy(0) !== 121 || sx(3) !== 323 || sy(3) !== 120 || len !== 7'd5) begin failures++; $display("FAIL self_hit_frozen got head=(%0d,%0d) seg3=(%0d,%0d) len=%0d exp (323,121) (323,120) 5", sx(0), sy(0), sx(3), sy(3), len); end
    buttons = 4'b0100; step1(); buttons = 4'b0000;
    checks++; if (hit !== 1'b0 || alive !== 1'b0 || sx(0) !== 323 || dir !== 2'd3) begin failures++; $display("FAIL dead_frozen got hit=%b alive=%b x=%0d dir=%0d exp 0 0 323 3", hit, alive, sx(0), dir); end
  endtask

  task automatic test_tail_vacate();
    apply_reset();
    press(4'b0100);
    for (int i = 0; i < 3; i++) grow_step();
    press(4'b0010); step1();
    press(4'b0001); step1();
    press(4'b1000); step1();
    checks++; if (hit !== 1'b0 || alive !== 1'b1 || moved !== 1'b1) begin failures++; $display("FAIL tail_vacate_flags got hit=%b alive=%b moved=%b exp 0 1 1", hit, alive, moved); end
    checks++; if (sx(0) !== 322 || sy(0) !== 120 || sx(1) !== 322 || sy(1) !== 121) begin failures++; $display("FAIL tail_vacate_head got=(%0d,%0d) seg1=(%0d,%0d) exp (322,120) (322,121)", sx(0), sy(0), sx(1), sy(1)); end
    checks++; if (sx(3) !== 323 || sy(3) !== 120 || sx(4) !== 0 || sy(4) !== 0 || len !== 7'd4) begin failures++; $display("FAIL tail_vacate_tail got seg3=(%0d,%0d) seg4=(%0d,%0d) len=%0d exp (323,120) (0,0) 4", sx(3), sy(3), sx(4), sy(4), len); end
  endtask

  task automatic test_reverse();
    apply_reset();
    press(4'b0100);
    for (int i = 0; i < 2; i++) grow_step();
    press(4'b0001);
    checks++; if (dir !== 2'd2 || len !== 7'd3) begin failures++; $display("FAIL reverse_len3 got dir=%0d len=%0d exp dir=2 len=3", dir, len); end
    apply_reset();
    press(4'b0100);
    press(4'b0001);
    checks++; if (dir !== 2'd0) begin failures++; $display("FAIL reverse_len1 got dir=%0d exp=0", dir); end
    step1();
    checks++; if (sx(0) !== 319) begin failures++; $display("FAIL reverse_len1_move got x=%0d exp=319", sx(0)); end
  endtask

  task automatic test_wrap();
    int n;
    apply_reset();
    press(4'b0001);
    n = 0;
    step = 1'b1;
    for (int i = 0; i < 320; i++) begin
      cyc();
      if (moved === 1'b1) n++;
    end
    step = 1'b0;
    checks++; if (n !== 320) begin failures++; $display("FAIL b2b_moved_count got=%0d exp=320", n); end
    checks++; if (sx(0) !== 0 || wx(0) !== 0 || alive_w !== 1'b1) begin failures++; $display("FAIL wrap_edge got x=%0d xw=%0d alive_w=%b exp 0 0 1", sx(0), wx(0), alive_w); end
    step1();
    checks++; if (sx(0) !== 639 || sy(0) !== 120 || hit !== 1'b0) begin failures++; $display("FAIL wrap_left got=(%0d,%0d) hit=%b exp=(639,120) 0", sx(0), sy(0), hit); end
    checks++; if (hit_w !== 1'b1 || alive_w !== 1'b0 || moved_w !== 1'b0 || wx(0) !== 0) begin failures++; $display("FAIL nowrap_wall got hit=%b alive=%b moved=%b x=%0d exp 1 0 0 0", hit_w, alive_w, moved_w, wx(0)); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    press(4'b0100);
    buttons = 4'b0010; step = 1'b1; cyc(); buttons = 4'b0000; step = 1'b0;
    checks++; if (sx(0) !== 321 || sy(0) !== 120 || dir !== 2'd1) begin failures++; $display("FAIL step_with_turn got=(%0d,%0d) dir=%0d exp=(321,120) 1", sx(0), sy(0), dir); end
    step1();
    checks++; if (sx(0) !== 321 || sy(0) !== 121) begin failures++; $display("FAIL turn_applied got=(%0d,%0d) exp=(321,121)", sx(0), sy(0)); end
    grow = 1'b1; step = 1'b1; cyc(); grow = 1'b0; step = 1'b0;
    checks++; if (len !== 7'd1 || sy(0) !== 122) begin failures++; $display("FAIL step_with_grow got len=%0d y=%0d exp 1 122", len, sy(0)); end
    step1();
    checks++; if (len !== 7'd2 || sy(0) !== 123 || sy(1) !== 122 || sx(1) !== 321) begin failures++; $display("FAIL held_grow got len=%0d y=%0d seg1=(%0d,%0d) exp 2 123 (321,122)", len, sy(0), sx(1), sy(1)); end
  endtask

  task automatic test_saturation();
    apply_reset();
    press(4'b0100);
    grow = 1'b1; cyc();
    step = 1'b1;
    for (int i = 0; i < 105; i++) cyc();
    checks++; if (len !== 7'd100) begin failures++; $display("FAIL sat_length got=%0d exp=100", len); end
    checks++; if (sx(0) !== 425 || sx(99) !== 326 || sy(99) !== 120) begin failures++; $display("FAIL sat_segs got head=%0d seg99=(%0d,%0d) exp 425 (326,120)", sx(0), sx(99), sy(99)); end
    reset_n = 1'b0;
    #2;
    checks++; if (sx(0) !== 320 || sy(0) !== 120 || len !== 7'd1 || dir !== 2'd0) begin failures++; $display("FAIL midstep_reset got=(%0d,%0d) len=%0d dir=%0d exp=(320,120) 1 0", sx(0), sy(0), len, dir); end
    checks++; if (sx(1) !== 0 || sx(99) !== 0 || sy(99) !== 0 || moved !== 1'b0 || alive !== 1'b1) begin failures++; $display("FAIL midstep_reset_body got seg1x=%0d seg99=(%0d,%0d) moved=%b alive=%b", sx(1), sx(99), sy(99), moved, alive); end
    step = 1'b0; grow = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    press(4'b0100);
    step1();
    checks++; if (len !== 7'd1 || sx(0) !== 321) begin failures++; $display("FAIL reset_clears_grow got len=%0d x=%0d exp 1 321", len, sx(0)); end
  endtask

  initial begin
    test_reset();
    test_start_move();
    test_grow();
    test_self_hit();
    test_tail_vacate();
    test_reverse();
    test_wrap();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

endmodule
